// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// id_ex_stage_if : decode-side inputs and EX-side outputs of the ID/EX stage
// Revision 1.0
// ============================================================================

interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [3:0]        id_MEM_signals;
  logic [6:0]        id_EX_signals;
  logic [2:0]        id_WB_signals;
  logic              id_flush;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic              branch_flush;
  logic              id_stall;
  logic              ex_valid;
  logic [3:0]        ex_MEM_signals;
  logic [6:0]        ex_EX_signals;
  logic [2:0]        ex_WB_signals;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_imm;

  modport master (
    output id_valid, id_instr, id_MEM_signals, id_EX_signals, id_WB_signals,
           id_flush, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, branch_flush,
    input  id_stall, ex_valid, ex_MEM_signals, ex_EX_signals, ex_WB_signals,
           ex_rs_data, ex_rt_data, ex_rd, ex_imm
  );

  modport slave (
    input  id_valid, id_instr, id_MEM_signals, id_EX_signals, id_WB_signals,
           id_flush, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, branch_flush,
    output id_stall, ex_valid, ex_MEM_signals, ex_EX_signals, ex_WB_signals,
           ex_rs_data, ex_rt_data, ex_rd, ex_imm
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : ID->EX register with load-use stall, two-word absorb, branch squash
// Revision 1.0
// ============================================================================

module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_ex_valid;
  logic [3:0]        r_ex_mem;
  logic [6:0]        r_ex_ex;
  logic [2:0]        r_ex_wb;
  logic [DATA_W-1:0] r_ex_rs_data;
  logic [DATA_W-1:0] r_ex_rt_data;
  logic [REG_AW-1:0] r_ex_rd;
  logic [DATA_W-1:0] r_ex_imm;

  logic              w_ex_valid_nxt;
  logic [3:0]        w_ex_mem_nxt;
  logic [6:0]        w_ex_ex_nxt;
  logic [2:0]        w_ex_wb_nxt;
  logic [DATA_W-1:0] w_ex_rs_data_nxt;
  logic [DATA_W-1:0] w_ex_rt_data_nxt;
  logic [REG_AW-1:0] w_ex_rd_nxt;
  logic [DATA_W-1:0] w_ex_imm_nxt;

  // First word of a two-word instruction, parked until its immediate arrives
  logic [3:0]        r_hold_mem;
  logic [6:0]        r_hold_ex;
  logic [2:0]        r_hold_wb;
  logic [DATA_W-1:0] r_hold_rs_data;
  logic [DATA_W-1:0] r_hold_rt_data;
  logic [REG_AW-1:0] r_hold_rd;

  logic [3:0]        w_hold_mem_nxt;
  logic [6:0]        w_hold_ex_nxt;
  logic [2:0]        w_hold_wb_nxt;
  logic [DATA_W-1:0] w_hold_rs_data_nxt;
  logic [DATA_W-1:0] w_hold_rt_data_nxt;
  logic [REG_AW-1:0] w_hold_rd_nxt;

  logic              w_hazard;
  logic              w_stall;

  // Conservative: both source indices are compared regardless of usage
  assign w_hazard = r_ex_valid & r_ex_mem[3] & r_ex_wb[2] &
                    ((r_ex_rd == bus.id_rs) | (r_ex_rd == bus.id_rt));

  always_comb begin
    w_state_nxt        = r_state;
    w_stall            = 1'b0;
    w_ex_valid_nxt     = 1'b0;
    w_ex_mem_nxt       = '0;
    w_ex_ex_nxt        = '0;
    w_ex_wb_nxt        = '0;
    w_ex_rs_data_nxt   = r_ex_rs_data;
    w_ex_rt_data_nxt   = r_ex_rt_data;
    w_ex_rd_nxt        = r_ex_rd;
    w_ex_imm_nxt       = r_ex_imm;
    w_hold_mem_nxt     = r_hold_mem;
    w_hold_ex_nxt      = r_hold_ex;
    w_hold_wb_nxt      = r_hold_wb;
    w_hold_rs_data_nxt = r_hold_rs_data;
    w_hold_rt_data_nxt = r_hold_rt_data;
    w_hold_rd_nxt      = r_hold_rd;

    case (r_state)
      RUN: begin
        if (bus.branch_flush) begin
          w_state_nxt = RUN;
        end else if (bus.id_valid && w_hazard) begin
          w_stall = 1'b1;
        end else if (bus.id_valid && bus.id_flush) begin
          w_hold_mem_nxt     = bus.id_MEM_signals;
          w_hold_ex_nxt      = bus.id_EX_signals;
          w_hold_wb_nxt      = bus.id_WB_signals;
          w_hold_rs_data_nxt = bus.id_rs_data;
          w_hold_rt_data_nxt = bus.id_rt_data;
          w_hold_rd_nxt      = bus.id_rd;
          w_state_nxt        = WAIT_IMM;
        end else if (bus.id_valid) begin
          w_ex_valid_nxt   = 1'b1;
          w_ex_mem_nxt     = bus.id_MEM_signals;
          w_ex_ex_nxt      = bus.id_EX_signals;
          w_ex_wb_nxt      = bus.id_WB_signals;
          w_ex_rs_data_nxt = bus.id_rs_data;
          w_ex_rt_data_nxt = bus.id_rt_data;
          w_ex_rd_nxt      = bus.id_rd;
          w_ex_imm_nxt     = '0;
        end
      end
      WAIT_IMM: begin
        if (bus.branch_flush) begin
          w_hold_mem_nxt     = '0;
          w_hold_ex_nxt      = '0;
          w_hold_wb_nxt      = '0;
          w_hold_rs_data_nxt = '0;
          w_hold_rt_data_nxt = '0;
          w_hold_rd_nxt      = '0;
          w_state_nxt        = RUN;
        end else if (bus.id_valid) begin
          // The immediate word is raw data, so flush/hazard on it are meaningless
          w_ex_valid_nxt   = 1'b1;
          w_ex_mem_nxt     = r_hold_mem;
          w_ex_ex_nxt      = r_hold_ex;
          w_ex_wb_nxt      = r_hold_wb;
          w_ex_rs_data_nxt = r_hold_rs_data;
          w_ex_rt_data_nxt = r_hold_rt_data;
          w_ex_rd_nxt      = r_hold_rd;
          w_ex_imm_nxt     = bus.id_instr;
          w_state_nxt      = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_ex_valid     <= 1'b0;
      r_ex_mem       <= '0;
      r_ex_ex        <= '0;
      r_ex_wb        <= '0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_rd        <= '0;
      r_ex_imm       <= '0;
      r_hold_mem     <= '0;
      r_hold_ex      <= '0;
      r_hold_wb      <= '0;
      r_hold_rs_data <= '0;
      r_hold_rt_data <= '0;
      r_hold_rd      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ex_valid     <= w_ex_valid_nxt;
      r_ex_mem       <= w_ex_mem_nxt;
      r_ex_ex        <= w_ex_ex_nxt;
      r_ex_wb        <= w_ex_wb_nxt;
      r_ex_rs_data   <= w_ex_rs_data_nxt;
      r_ex_rt_data   <= w_ex_rt_data_nxt;
      r_ex_rd        <= w_ex_rd_nxt;
      r_ex_imm       <= w_ex_imm_nxt;
      r_hold_mem     <= w_hold_mem_nxt;
      r_hold_ex      <= w_hold_ex_nxt;
      r_hold_wb      <= w_hold_wb_nxt;
      r_hold_rs_data <= w_hold_rs_data_nxt;
      r_hold_rt_data <= w_hold_rt_data_nxt;
      r_hold_rd      <= w_hold_rd_nxt;
    end
  end

  assign bus.id_stall       = w_stall;
  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_MEM_signals = r_ex_mem;
  assign bus.ex_EX_signals  = r_ex_ex;
  assign bus.ex_WB_signals  = r_ex_wb;
  assign bus.ex_rs_data     = r_ex_rs_data;
  assign bus.ex_rt_data     = r_ex_rt_data;
  assign bus.ex_rd          = r_ex_rd;
  assign bus.ex_imm         = r_ex_imm;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage: registers the control unit's MEM/EX/WB signal groups and the decoded operands into the EX stage. It also performs three jobs.
- Detects load-use hazards, stalls decode for one cycle and inserts a bubble.
- Absorbs two-word instructions by holding the first word until the immediate word arrives.
- Squashes on a taken branch.

It sits between the control unit/register file and the execute stage.

## Interface
- DATA_W, 16, register/instruction word width
- REG_AW, 3, register index width
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a valid word
- id_instr  in  DATA_W  raw decode word; used as the immediate in WAIT_IMM
- id_MEM_signals  in  4  {memRead, memWrite, memAddress, memData}
- id_EX_signals  in  7  ALU op/enable, shamt select, flag_en
- id_WB_signals  in  3  {regWrite, WBsel[1:0]}
- id_flush  in  1  control-unit flag: the next decode word is this instruction's immediate
- id_rs, id_rt, id_rd  in  REG_AW  source/destination indices
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- branch_flush  in  1  taken jump/call/ret from EX; kill the instruction in decode
- id_stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_MEM_signals, ex_EX_signals, ex_WB_signals  out  4/7/3  registered control groups
- ex_rs_data, ex_rt_data  out  DATA_W  registered operands
- ex_rd  out  REG_AW  registered destination index
- ex_imm  out  DATA_W  registered immediate; 0 for one-word instructions

## Operation
- FSM states: RUN and WAIT_IMM. Reset state is RUN.
- Hazard definition: `hazard = ex_valid & ex_MEM_signals[3] & ex_WB_signals[2] & (ex_rd==id_rs | ex_rd==id_rt)`.
  - The check is conservative: both indices are always compared, whether or not the instruction uses them.
- RUN priority, first match wins:
  1. branch_flush: issue a bubble.
  2. id_valid & hazard: issue a bubble and assert id_stall.
  3. id_valid & id_flush: capture MEM/EX/WB, rs/rt data and rd into hold registers; issue a bubble; go to WAIT_IMM.
  4. id_valid: issue the decode instruction with ex_imm=0.
  5. Otherwise: issue a bubble.
- WAIT_IMM priority, first match wins:
  1. branch_flush: discard the hold registers, issue a bubble, go to RUN.
  2. id_valid: issue the held instruction with ex_imm=id_instr, go to RUN. id_flush and hazard are ignored, because the immediate word is not decoded.
  3. Otherwise: issue a bubble and remain in WAIT_IMM.
- Bubble: ex_valid=0 and ex_MEM/EX/WB_signals=0. ex_rs_data, ex_rt_data, ex_rd and ex_imm keep their previous values.
- id_stall is asserted only in RUN when `id_valid & hazard & ~branch_flush`. It is never asserted in WAIT_IMM.
- Operands of a two-word instruction are those sampled with the first word. Register-file write-before-read and EX forwarding resolve any later writes.

## Timing
- Reset: all outputs are 0, the FSM is in RUN, and the hold registers are cleared.
  - Reset asserted mid-WAIT_IMM discards the held instruction immediately.
- Latency:
  - One-word instruction: 1 cycle from decode to EX outputs.
  - Two-word instruction: 1 cycle after the immediate word is accepted.
- Load-use costs exactly one bubble.
  - The cycle after the stall, ex_valid=0, so hazard=0 and the held decode word issues.
- branch_flush has priority over stall, capture and issue in the same cycle.
- A stalled id word must be presented unchanged in the next cycle. Fetch guarantees this via id_stall.
- Bubbles never alter operand or data registers; only ex_valid and the control groups change.

## Test plan
- Reset: drive rst_n low mid-cycle → all outputs 0 asynchronously. Release, then ADD (EX=0010101, WB=101, rd=2) → next edge ex_valid=1, ex_EX_signals=0010101, ex_WB_signals=101, ex_rd=2, ex_imm=0.
- Load-use: load in EX (MEM=1000, WB=110, rd=3), decode word has rs=3 → id_stall=1 for one cycle and a bubble (ex_valid=0, signals 0). Next edge: the dependent instruction issues with id_stall=0.
- Two-word: LDM (id_flush=1, MEM=1000, WB=110, rd=5), then the immediate word 0xBEEF after two idle cycles → bubbles while in WAIT_IMM. On acceptance: ex_valid=1, ex_MEM_signals=1000, ex_rd=5, ex_imm=0xBEEF.
- Branch in WAIT_IMM: LDM captured, then branch_flush=1 together with id_valid → bubble and FSM in RUN. The next id_valid ADD issues normally with ex_imm=0.
- Simultaneous events: hazard condition and branch_flush in the same cycle → id_stall=0 and a bubble. No-match case: ex_rd=1, id_rs=2, id_rt=4 → no stall, instruction issues.
- Idle: id_valid=0 for 3 cycles in RUN → ex_valid=0 each cycle; ex_rs_data keeps its last value.
